// File: rtl/avmm_seq_pkg.sv
// Shared constants, state encoding and address packing
// for the Avalon-MM evaluation sequencer.
package avmm_seq_pkg;

  localparam logic [11:0] VID_OL    = 12'd15;
  localparam logic [11:0] VID_TASK  = 12'd11;
  localparam logic [11:0] VID_CONT  = 12'd12;
  localparam logic [11:0] VID_DONE  = 12'd14;
  localparam logic [11:0] VID_UPD   = 12'd8;
  localparam logic [11:0] VID_APPLY = 12'd9;
  localparam logic [11:0] VID_RST   = 12'd13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_OL,
    S_RD_TASK,
    S_TASK_WAIT,
    S_WR_CONT,
    S_RD_DONE,
    S_RD_UPD,
    S_WR_APPLY,
    S_RD_OL,
    S_WR_RST,
    S_FIN
  } state_e;

  function automatic logic [15:0] addr_pack(
    input logic [1:0]  mid,
    input logic [11:0] vid
  );
    return {2'b00, mid, vid};
  endfunction

endpackage

// File: rtl/avmm_master_port.sv
// Avalon-MM issue/hold/complete handshake with
// registered strobes and read-data capture.
module avmm_master_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [15:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (rd_q || wr_q) begin
      if (!m_waitrequest) begin
        rd_d  = 1'b0;
        wr_d  = 1'b0;
        ack_d = 1'b1;
        if (rd_q) rdata_d = m_readdata;
      end
    end else if (req && !ack_q) begin
      // ack_q gates re-issue while the FSM is still leaving the state
      rd_d    = !we;
      wr_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign m_address   = addr_q;
  assign m_read      = rd_q;
  assign m_write     = wr_q;
  assign m_writedata = wdata_q;

endmodule

// File: rtl/avmm_eval_sequencer.sv
// Hardware evaluation loop driving the program_logic
// slave: iterate, hand off tasks, apply updates.
module avmm_eval_sequencer #(
  parameter int MID_W      = 2,
  parameter int POLL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MID_W-1:0] start_mid,
  input  logic [31:0]      start_iters,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             task_valid,
  output logic [31:0]      task_id,
  input  logic             task_ack,
  output logic [15:0]      m_address,
  output logic             m_read,
  output logic             m_write,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             m_waitrequest
);
  import avmm_seq_pkg::*;

  state_e           state_q, state_d;
  logic [MID_W-1:0] mid_q, mid_d;
  logic [31:0]      iters_q, iters_d;
  logic [31:0]      poll_q, poll_d;
  logic [31:0]      task_id_q, task_id_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             tv_q, tv_d;

  logic        req, we, ack;
  logic [11:0] vid;
  logic [31:0] wdata, rdata, poll_inc;
  logic        rd_nz;

  always_comb begin
    req   = 1'b1;
    we    = 1'b0;
    vid   = VID_TASK;
    wdata = '0;
    unique case (state_q)
      S_WR_OL: begin
        we    = 1'b1;
        vid   = VID_OL;
        wdata = iters_q;
      end
      S_RD_TASK:  vid = VID_TASK;
      S_WR_CONT: begin
        we  = 1'b1;
        vid = VID_CONT;
      end
      S_RD_DONE:  vid = VID_DONE;
      S_RD_UPD:   vid = VID_UPD;
      S_WR_APPLY: begin
        we  = 1'b1;
        vid = VID_APPLY;
      end
      S_RD_OL:    vid = VID_OL;
      S_WR_RST: begin
        we  = 1'b1;
        vid = VID_RST;
      end
      default:    req = 1'b0;
    endcase
  end

  assign rd_nz    = |rdata;
  assign poll_inc = (&poll_q) ? poll_q : poll_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    mid_d     = mid_q;
    iters_d   = iters_q;
    poll_d    = poll_q;
    task_id_d = task_id_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WR_OL;
        mid_d   = start_mid;
        iters_d = start_iters;
        poll_d  = '0;
      end
      S_WR_OL: if (ack) state_d = S_RD_TASK;
      S_RD_TASK: if (ack) begin
        if (rd_nz) begin
          state_d   = S_TASK_WAIT;
          task_id_d = rdata;
          poll_d    = '0;
        end else begin
          state_d = S_RD_DONE;
        end
      end
      S_TASK_WAIT: begin
        if (abort)         state_d = S_WR_RST;
        else if (task_ack) state_d = S_WR_CONT;
      end
      S_WR_CONT: if (ack) state_d = S_RD_TASK;
      S_RD_DONE: if (ack) begin
        if (rdata[0]) begin
          poll_d  = '0;
          state_d = S_RD_UPD;
        end else begin
          poll_d  = poll_inc;
          state_d = (poll_inc >= 32'(POLL_LIMIT))
                  ? S_WR_RST : S_RD_TASK;
        end
      end
      S_RD_UPD:   if (ack) state_d = rd_nz ? S_WR_APPLY : S_RD_OL;
      S_WR_APPLY: if (ack) state_d = S_RD_TASK;
      S_RD_OL:    if (ack) state_d = rd_nz ? S_RD_TASK : S_FIN;
      S_WR_RST:   if (ack) state_d = S_IDLE;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (ack && abort && state_q != S_WR_RST) state_d = S_WR_RST;
  end

  // Flag outputs are decoded from the next state so they stay registered
  assign busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
  assign done_d  = (state_d == S_FIN);
  assign error_d = (state_q == S_WR_RST) && ack;
  assign tv_d    = (state_d == S_TASK_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mid_q     <= '0;
      iters_q   <= '0;
      poll_q    <= '0;
      task_id_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      tv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mid_q     <= mid_d;
      iters_q   <= iters_d;
      poll_q    <= poll_d;
      task_id_q <= task_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      tv_q      <= tv_d;
    end
  end

  avmm_master_port u_port (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .addr         (addr_pack(2'(mid_q), vid)),
    .wdata        (wdata),
    .ack          (ack),
    .rdata        (rdata),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign task_valid = tv_q;
  assign task_id    = task_id_q;

endmodule

// File: tb/tb_avmm_eval_sequencer.sv
// Directed bench for avmm_eval_sequencer with a
// scripted zero-latency program_logic slave.
module tb_avmm_eval_sequencer;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  start_mid = '0;
  logic [31:0] start_iters = '0;
  logic        abort = 1'b0;
  logic        task_ack = 1'b0;
  logic        busy, done, error, task_valid;
  logic [31:0] task_id;
  logic [15:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata, m_readdata;
  logic        m_waitrequest;

  logic [31:0] task_val = '0;
  logic [31:0] done_val = 32'd1;
  logic [31:0] ol_val = '0;
  int          upd_cnt = 0;
  int          stall_left = 0;

  txn_t log_q[$];
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   strobe_cyc = 0;
  int   bad_pulse = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  avmm_eval_sequencer #(.MID_W(2), .POLL_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_mid    (start_mid),
    .start_iters  (start_iters),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .task_valid   (task_valid),
    .task_id      (task_id),
    .task_ack     (task_ack),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  assign m_waitrequest = (stall_left != 0) && m_read
                      && (m_address[11:0] == 12'd11);

  always_comb begin
    m_readdata = '0;
    case (m_address[11:0])
      12'd11:  m_readdata = task_val;
      12'd14:  m_readdata = done_val;
      12'd8:   m_readdata = {31'd0, upd_cnt != 0};
      12'd15:  m_readdata = ol_val;
      default: m_readdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (m_waitrequest) stall_left <= stall_left - 1;
    if ((m_read || m_write) && !m_waitrequest) begin
      log_q.push_back({m_write, m_address, m_writedata});
      if (m_read && m_address[11:0] == 12'd11) task_val <= '0;
      if (m_read && m_address[11:0] == 12'd8 && upd_cnt != 0)
        upd_cnt <= upd_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (m_read || m_write) strobe_cyc <= strobe_cyc + 1;
    if ((done || error) && busy) bad_pulse <= bad_pulse + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_txn(input string tag, input int idx,
                         input logic we, input logic [15:0] a);
    logic [31:0] got;
    got = 32'hDEAD_BEEF;
    if (idx < log_q.size())
      got = {15'd0, log_q[idx].we, log_q[idx].addr};
    chk(tag, got, {15'd0, we, a});
  endtask

  task automatic do_start(input logic [1:0] mid, input logic [31:0] it);
    @(negedge clk);
    start = 1'b1;
    start_mid = mid;
    start_iters = it;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(tag, {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tv(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (task_valid) break;
      @(negedge clk);
    end
    chk(tag, {31'd0, task_valid}, 32'd1);
  endtask

  initial begin
    int b, d0, e0, s0, n14, stable;

    repeat (3) @(negedge clk);
    chk("rst_flags", {26'd0, busy, done, error, task_valid, m_read, m_write},
        32'd0);
    chk("rst_addr", {16'd0, m_address}, 32'd0);
    chk("rst_wdata", m_writedata, 32'd0);
    chk("rst_tid", task_id, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic pass: no task, done, no update, open loop exhausted
    b = log_q.size();
    d0 = done_cnt;
    do_start(2'd1, 32'd0);
    chk("t1_lat0", {31'd0, m_write}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_lat1", {31'd0, m_write}, 32'd1);
    chk("t1_addr", {16'd0, m_address}, 32'h100F);
    wait_idle("t1_idle");
    chk("t1_n", log_q.size() - b, 32'd5);
    chk_txn("t1_x0", b + 0, 1'b1, 16'h100F);
    chk_txn("t1_x1", b + 1, 1'b0, 16'h100B);
    chk_txn("t1_x2", b + 2, 1'b0, 16'h100E);
    chk_txn("t1_x3", b + 3, 1'b0, 16'h1008);
    chk_txn("t1_x4", b + 4, 1'b0, 16'h100F);
    chk("t1_done", done_cnt - d0, 32'd1);

    // one task handed to the host and acknowledged late
    task_val <= 32'd5;
    b = log_q.size();
    d0 = done_cnt;
    do_start(2'd1, 32'd3);
    wait_tv("t2_tv");
    chk("t2_tid", task_id, 32'd5);
    s0 = strobe_cyc;
    repeat (20) @(negedge clk);
    chk("t2_quiet", strobe_cyc - s0, 32'd0);
    task_ack = 1'b1;
    @(negedge clk);
    task_ack = 1'b0;
    chk("t2_tv_drop", {31'd0, task_valid}, 32'd0);
    chk("t2_ack_lat0", {31'd0, m_write}, 32'd0);
    @(negedge clk);
    chk("t2_ack_lat1", {31'd0, m_write}, 32'd1);
    chk("t2_cont_addr", {16'd0, m_address}, 32'h100C);
    wait_idle("t2_idle");
    chk_txn("t2_x2", b + 2, 1'b1, 16'h100C);
    chk_txn("t2_x3", b + 3, 1'b0, 16'h100B);
    chk("t2_done", done_cnt - d0, 32'd1);

    // two pending updates on module 2
    upd_cnt <= 2;
    b = log_q.size();
    d0 = done_cnt;
    do_start(2'd2, 32'd7);
    wait_idle("t3_idle");
    chk("t3_n", log_q.size() - b, 32'd13);
    chk("t3_ol_data", (log_q.size() > b) ? log_q[b].data : 32'hDEAD_BEEF,
        32'd7);
    chk_txn("t3_x4", b + 4, 1'b1, 16'h2009);
    chk_txn("t3_x8", b + 8, 1'b1, 16'h2009);
    chk_txn("t3_x12", b + 12, 1'b0, 16'h200F);
    chk("t3_done", done_cnt - d0, 32'd1);

    // done never set: poll timeout after four vid-14 reads
    done_val <= 32'd0;
    b = log_q.size();
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(2'd1, 32'd0);
    wait_idle("t4_idle");
    n14 = 0;
    for (int i = b; i < log_q.size(); i++)
      if (!log_q[i].we && log_q[i].addr == 16'h100E) n14++;
    chk("t4_polls", n14, 32'd4);
    chk("t4_n", log_q.size() - b, 32'd10);
    chk_txn("t4_last", log_q.size() - 1, 1'b1, 16'h100D);
    chk("t4_err", err_cnt - e0, 32'd1);
    chk("t4_nodone", done_cnt - d0, 32'd0);
    done_val <= 32'd1;

    // stalled task read with abort during the stall
    stall_left <= 7;
    b = log_q.size();
    e0 = err_cnt;
    do_start(2'd1, 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (m_read && m_address == 16'h100B) break;
      @(negedge clk);
    end
    stable = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_read && m_address == 16'h100B) stable++;
      if (i == 2) abort = 1'b1;
      @(negedge clk);
    end
    chk("t5_stable", stable, 32'd8);
    chk("t5_released", {31'd0, m_read}, 32'd0);
    wait_idle("t5_idle");
    abort = 1'b0;
    chk("t5_n", log_q.size() - b, 32'd3);
    chk_txn("t5_x2", b + 2, 1'b1, 16'h100D);
    chk("t5_err", err_cnt - e0, 32'd1);

    // abort and task_ack together: abort wins
    task_val <= 32'h9;
    b = log_q.size();
    e0 = err_cnt;
    do_start(2'd1, 32'd0);
    wait_tv("t6_tv");
    abort = 1'b1;
    task_ack = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    task_ack = 1'b0;
    wait_idle("t6_idle");
    chk("t6_n", log_q.size() - b, 32'd3);
    chk_txn("t6_x2", b + 2, 1'b1, 16'h100D);
    chk("t6_err", err_cnt - e0, 32'd1);

    // reset mid-write, then a normal run
    do_start(2'd1, 32'd0);
    @(negedge clk);
    chk("t7_pre", {31'd0, m_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t7_flags", {26'd0, busy, done, error, task_valid, m_read, m_write},
        32'd0);
    chk("t7_addr", {16'd0, m_address}, 32'd0);
    chk("t7_tid", task_id, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b = log_q.size();
    d0 = done_cnt;
    do_start(2'd1, 32'd0);
    wait_idle("t7_idle");
    chk("t7_n", log_q.size() - b, 32'd5);
    chk_txn("t7_x4", b + 4, 1'b0, 16'h100F);
    chk("t7_done", done_cnt - d0, 32'd1);

    chk("pulse_busy", bad_pulse, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avmm_eval_sequencer.md
# avmm_eval_sequencer

Avalon-MM master that runs the per-module evaluation loop of a `program_logic` slave in hardware, in place of host software. On a start command it:
- programs the open-loop iteration count;
- polls task, done and update status;
- hands pending tasks to the host and resumes after acknowledgement;
- applies pending updates until the module is quiescent.

It sits between the host command interface and the `s0_*` slave port of `program_logic`.

## Interface
- `MID_W`, 2: module-id width; the address is `{2'b00, mid, vid[11:0]}`.
- `POLL_LIMIT`, 1024: consecutive not-done polls allowed before the timeout abort.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low; low = reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `start_mid`  in  MID_W  target module id.
- `start_iters`  in  32  open-loop count written to vid 15.
- `abort`  in  1  level; honoured at the next bus-transaction boundary.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `error`  out  1  one-cycle pulse on timeout or abort completion.
- `task_valid`  out  1  task pending for the host.
- `task_id`  out  32  value read from vid 11; valid while `task_valid`.
- `task_ack`  in  1  host finished the task; ignored unless `task_valid`.
- `m_address`  out  16  master address.
- `m_read`, `m_write`  out  1  request strobes.
- `m_writedata`  out  32  write data.
- `m_readdata`  in  32  read data.
- `m_waitrequest`  in  1  slave stall.

## Operation
- States: IDLE, WR_OL, RD_TASK, TASK_WAIT, WR_CONT, RD_DONE, RD_UPD, WR_APPLY, RD_OL, WR_RST, FIN.
- Every bus state holds its strobe, address and data constant until a cycle with `m_waitrequest`=0. That cycle completes the transaction and captures read data.
- IDLE
  - On `start`, latch mid and iters, then go to WR_OL.
- WR_OL
  - Write vid 15 with the latched iters, then go to RD_TASK.
- RD_TASK
  - Read vid 11.
  - Nonzero: latch `task_id` and go to TASK_WAIT.
  - Zero: go to RD_DONE.
- TASK_WAIT
  - `task_valid`=1, no bus activity.
  - On `task_ack`: drop `task_valid` and go to WR_CONT.
- WR_CONT
  - Write vid 12 with data 0, then go to RD_TASK.
- RD_DONE
  - Read vid 14.
  - Bit0=1: clear the poll counter and go to RD_UPD.
  - Bit0=0: increment the poll counter.
    - If the counter is ≥ POLL_LIMIT, go to WR_RST with error.
    - Otherwise go to RD_TASK.
- RD_UPD
  - Read vid 8.
  - Nonzero: go to WR_APPLY.
  - Zero: go to RD_OL.
- WR_APPLY
  - Write vid 9, then go to RD_TASK.
- RD_OL
  - Read vid 15.
  - Nonzero: go to RD_TASK.
  - Zero: go to FIN.
- FIN
  - Pulse `done`, then go to IDLE.
- WR_RST
  - Write vid 13, pulse `error`, then go to IDLE.
- Abort
  - When `abort` is high at a transaction completion, or in TASK_WAIT, the next state is WR_RST instead of the normal successor.
  - If abort coincides with `task_ack`, abort wins.
- Poll counter
  - 32-bit, saturating.
  - Cleared on `start` and on any nonzero task read.

## Timing
- Reset values:
  - state IDLE.
  - All strobes, `busy`, `done`, `error` and `task_valid` are 0.
  - `m_address`, `m_writedata` and `task_id` are 0.
- Asserting reset mid-transaction drops the strobes immediately; no completion is owed to the slave.
- All outputs are registered.
- The strobe rises the cycle after entering a bus state and falls the cycle after the `m_waitrequest`=0 completion. There is at least one idle cycle between transactions, which the slave needs for its read-edge detection.
- `start` to first `m_write`: 1 cycle.
- `task_ack` to the WR_CONT strobe: 1 cycle.
- `done`/`error` pulse one cycle after the last completion. `busy` falls in the same cycle as that pulse.
- A `start` while `busy` is dropped.

## Structure
- Package `avmm_seq_pkg` holds:
  - vid constants: OL=15, TASK=11, CONT=12, DONE=14, UPD=8, APPLY=9, RST=13;
  - the state enum;
  - the address-pack function.
- Sub-module `avmm_master_port` owns the issue/hold/complete handshake and read-data capture. It exposes `req`, `we`, `addr`, `wdata`, `ack` (single-cycle pulse) and `rdata` to the FSM.

## Test plan
- Zero-latency slave model; mid=1, iters=0; slave reports task=0, done=1, upd=0, ol=0 → transactions in order: write 0x100F←0, then reads 0x100B, 0x100E, 0x1008, 0x100F; `done` pulses once.
- Slave returns task=5 once → `task_valid`=1 with `task_id`=5. Hold `task_ack` off for 20 cycles → no bus traffic during that time. Then `task_ack` → write 0x100C, followed by a re-read of vid 11.
- upd=1 for two reads, then 0 → two writes to vid 9 occur before the vid 15 read.
- done held at 0, POLL_LIMIT=4 → exactly 4 vid-14 reads, then a write to vid 13, then an `error` pulse.
- `m_waitrequest` held high for 7 cycles on the vid-11 read → strobe and address stable for 8 cycles. Assert `abort` during the stall → next transaction is the vid-13 write.
- Reset pulled low while `m_write` is asserted → all outputs 0 in the same cycle. A `start` after release works normally.
